dcache_ctrl: RTL



---
 rtl/dcache_ctrl_if.sv | 31 +++
 rtl/dcache_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl_if.sv
// Core-side and memory-side signal bundle of the data cache controller.
// The slave modport is the controller's view; master is the view of
// whatever surrounds it (pipeline plus memory model).
interface dcache_ctrl_if #(
  parameter int bit_size = 32
);
  // core (MEM stage) side
  logic [bit_size-1:0] core_addr;
  logic                core_read;
  logic                core_write;
  logic [bit_size-1:0] core_wdata;
  logic [bit_size-1:0] core_rdata;
  logic                DC_stall;
  // memory side
  logic                mem_req;
  logic                mem_we;
  logic [bit_size-1:0] mem_addr;
  logic [bit_size-1:0] mem_wdata;
  logic [bit_size-1:0] mem_rdata;
  logic                mem_ready;

  modport slave (
    input  core_addr, core_read, core_write, core_wdata, mem_rdata, mem_ready,
    output core_rdata, DC_stall, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output core_addr, core_read, core_write, core_wdata, mem_rdata, mem_ready,
    input  core_rdata, DC_stall, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Loads hit combinationally; a load miss refills the whole 4-word line one
// beat at a time, and every store is written through to memory while the
// pipeline is frozen via DC_stall. Stores that hit also update the line.
module dcache_ctrl #(
  parameter int bit_size = 32,
  parameter int idx_bits = 4
) (
  input  logic          clk,
  input  logic          rst,
  dcache_ctrl_if.slave  dc_bus
);

  localparam int TAG_W  = bit_size - 4 - idx_bits;
  localparam int NLINES = 1 << idx_bits;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2,
    WDONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  // control state (reset)
  logic [NLINES-1:0]   valid_q;
  logic [1:0]          cnt_q, cnt_d;

  // latched request fields (not reset; only consumed after being loaded)
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [idx_bits-1:0] idx_q, idx_d;
  logic [bit_size-1:2] waddr_q, waddr_d;
  logic [bit_size-1:0] wdata_q, wdata_d;
  logic                whit_q, whit_d;

  // line storage (not reset)
  logic [TAG_W-1:0]    tags_q [NLINES];
  logic [bit_size-1:0] data_q [NLINES][4];

  // address decode of the incoming request
  logic [TAG_W-1:0]    a_tag;
  logic [idx_bits-1:0] a_idx;
  logic [1:0]          a_off;
  logic                hit;
  logic                rd_req;
  logic                wr_req;
  logic                unused_addr_lsb;

  assign a_off  = dc_bus.core_addr[3:2];
  assign a_idx  = dc_bus.core_addr[3+idx_bits:4];
  assign a_tag  = dc_bus.core_addr[bit_size-1:4+idx_bits];
  assign hit    = valid_q[a_idx] && (tags_q[a_idx] == a_tag);
  // reset masks the requests so nothing stalls or reads while it is held
  assign rd_req = dc_bus.core_read  & ~rst;
  assign wr_req = dc_bus.core_write & ~rst;
  assign unused_addr_lsb = ^dc_bus.core_addr[1:0];

  // array write port, shared by refill beats and write-through hits
  logic                arr_we;
  logic [idx_bits-1:0] arr_idx;
  logic [1:0]          arr_off;
  logic [bit_size-1:0] arr_wdata;
  logic                line_fill;

  logic                stall;
  logic [bit_size-1:0] rdata;
  logic                mreq;
  logic                mwe;
  logic [bit_size-1:0] maddr;
  logic [bit_size-1:0] mwdata;

  // next-state, array write controls and Mealy outputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tag_d     = tag_q;
    idx_d     = idx_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    whit_d    = whit_q;
    arr_we    = 1'b0;
    arr_idx   = '0;
    arr_off   = '0;
    arr_wdata = '0;
    line_fill = 1'b0;
    stall     = 1'b0;
    rdata     = '0;
    mreq      = 1'b0;
    mwe       = 1'b0;
    maddr     = '0;
    mwdata    = '0;
    case (state_q)
      IDLE: begin
        if (wr_req) begin
          // a simultaneous read is treated as a write
          stall   = 1'b1;
          waddr_d = dc_bus.core_addr[bit_size-1:2];
          wdata_d = dc_bus.core_wdata;
          whit_d  = hit;
          state_d = WRITE;
        end else if (rd_req) begin
          if (hit) begin
            rdata = data_q[a_idx][a_off];
          end else begin
            stall   = 1'b1;
            tag_d   = a_tag;
            idx_d   = a_idx;
            cnt_d   = 2'd0;
            state_d = REFILL;
          end
        end
      end
      REFILL: begin
        stall = 1'b1;
        mreq  = 1'b1;
        maddr = {tag_q, idx_q, cnt_q, 2'b00};
        if (dc_bus.mem_ready) begin
          arr_we    = 1'b1;
          arr_idx   = idx_q;
          arr_off   = cnt_q;
          arr_wdata = dc_bus.mem_rdata;
          cnt_d     = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            line_fill = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      WRITE: begin
        stall  = 1'b1;
        mreq   = 1'b1;
        mwe    = 1'b1;
        maddr  = {waddr_q, 2'b00};
        mwdata = wdata_q;
        if (dc_bus.mem_ready) begin
          if (whit_q) begin
            arr_we    = 1'b1;
            arr_idx   = waddr_q[3+idx_bits:4];
            arr_off   = waddr_q[3:2];
            arr_wdata = wdata_q;
          end
          state_d = WDONE;
        end
      end
      WDONE: begin
        // the store retires this cycle; core_write is still up and ignored
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // control registers: FSM state, beat counter, valid bits
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (line_fill) valid_q[idx_q] <= 1'b1;
    end
  end

  // latched request fields
  always_ff @(posedge clk) begin
    tag_q   <= tag_d;
    idx_q   <= idx_d;
    waddr_q <= waddr_d;
    wdata_q <= wdata_d;
    whit_q  <= whit_d;
  end

  // tag and data arrays; writes are suppressed while reset is held
  always_ff @(posedge clk) begin
    if (arr_we && !rst) data_q[arr_idx][arr_off] <= arr_wdata;
    if (line_fill && !rst) tags_q[idx_q] <= tag_q;
  end

  assign dc_bus.DC_stall   = stall;
  assign dc_bus.core_rdata = rdata;
  assign dc_bus.mem_req    = mreq;
  assign dc_bus.mem_we     = mwe;
  assign dc_bus.mem_addr   = maddr;
  assign dc_bus.mem_wdata  = mwdata;

endmodule
